bit_scan_sequencer: RTL and testbench
=====================================

Name: bit_scan_sequencer

Overview:
Sequential set-bit enumerator for a 32-bit word. It accepts a word through a valid/ready handshake and isolates one set bit per beat (lowest or highest first). Each isolated one-hot vector goes through the shared one-hot-to-index decoder, and the block emits one bit index per accepted output beat. After the last index it pulses done with the population count. Used by the RISC core for register-list and mask walks (multi-register load/store, interrupt-pending scans).

Parameters:
LSB_FIRST, 1, 1 = enumerate from bit 0 upward; 0 = enumerate from bit 31 downward.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  word offered
in_ready  output  1  block can accept a word (high only in IDLE)
in_word  input  32  word to enumerate
abort  input  1  synchronous flush of the current scan
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts the current index
out_idx  output  5  bit position 0..31 of the current set bit
out_last  output  1  current index is the final set bit
done  output  1  one-cycle pulse, scan complete
pop_count  output  6  number of set bits (0..32); valid when done is high, held until the next done

Behaviour:
- Reset (async, rst_n low): state IDLE, rem = 0, count = 0, done = 0, pop_count = 0. Outputs: in_ready = 1, out_valid = 0, out_idx = 0, out_last = 0.
- FSM states: IDLE, SCAN, FIN.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: rem <= in_word, count <= 0.
  - Next state SCAN if in_word != 0, else FIN.
- SCAN:
  - out_valid = 1.
  - Isolation: onehot = rem & (~rem + 1) when LSB_FIRST = 1. When LSB_FIRST = 0, bit-reverse rem, apply the same isolation, then reverse back.
  - onehot drives decoder diff; out_idx = diff_out − 1, truncated to 5 bits.
  - out_last = 1 iff (rem & ~onehot) == 0.
  - On out_valid & out_ready: rem <= rem & ~onehot, count <= count + 1. If out_last, next state FIN.
  - Without out_ready: rem, out_idx and out_last stay stable (no beat lost or repeated).
- FIN:
  - done = 1 for exactly one cycle.
  - pop_count <= count; on the zero-word path it is 0.
  - Next state IDLE.
  - in_ready = 0 in this cycle.
- Latency:
  - First index is valid the cycle after input acceptance.
  - Sustained rate is one index per cycle with out_ready held high.
  - done asserts the cycle after the last beat's handshake.
  - Total for N set bits with no backpressure: N + 2 cycles from acceptance to the return to IDLE.
- abort:
  - Highest priority below reset, in any state: next state IDLE, rem <= 0, count <= 0.
  - No done pulse; pop_count unchanged.
  - A beat presented in the abort cycle counts as not consumed.
  - abort in IDLE with in_valid high: the word is dropped; abort wins.
- Decoder eq = 1 or the default (non-one-hot) arm while in SCAN is unreachable. Defensive rule: treat it as last and go to FIN.
- count width is 6 bits; 32 set bits gives 6'd32 with no wrap.
- Reset mid-scan returns to the reset values immediately, regardless of handshake state.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2), WORD_W = 32, IDX_W = 5, CNT_W = 6.
- One sub-module instance: binary_to_bcd (existing one-hot-to-index decoder; diff_out gives position + 1, eq flags zero).
- Bit-reverse is a generate loop inside this block, not a separate module.

Test Plan:
1. Zero word, in_word = 32'h0000_0000 accepted → no out_valid. done pulses for one cycle in the 2nd cycle after acceptance with pop_count = 0. in_ready back high the cycle after.
2. LSB_FIRST = 1, in_word = 32'h8000_0001, out_ready = 1 → beats idx 0 (last = 0) then idx 31 (last = 1). done follows with pop_count = 2.
3. LSB_FIRST = 0, in_word = 32'h0000_0112 → beats 8, 4, 1 with last only on 1. pop_count = 3.
4. Backpressure, in_word = 32'h0000_00A0, out_ready low for 3 cycles after out_valid rises → out_idx held at 5 for those cycles. Then beats 5, 7 in order, no duplicates; pop_count = 2.
5. Full word, in_word = 32'hFFFF_FFFF, out_ready = 1 → 32 consecutive beats with idx 0..31 and last only on 31. pop_count = 32. Total 34 cycles from acceptance to IDLE.
6. Abort/reset: abort asserted after 2 beats of 32'h0000_F000 → IDLE next cycle, no done, pop_count keeps its prior value. Separately, rst_n low mid-SCAN → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/bit_scan_sequencer_pkg.sv
// Shared definitions for the bit-scan sequencer: word/index/count widths and
// the scan FSM state encoding.
package bit_scan_sequencer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_scan_sequencer_if.sv
// Handshake bundle for the bit-scan sequencer.
//   in_valid/in_ready/in_word : word input handshake
//   abort                     : synchronous flush of the current scan
//   out_valid/out_ready       : index output handshake
//   out_idx/out_last          : current bit index and final-beat flag
//   done/pop_count            : completion pulse and population count
// slave  = sequencer side, master = producer/consumer side.
interface bit_scan_sequencer_if;
    import bit_scan_sequencer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              done;
    logic [CNT_W-1:0]  pop_count;

    modport slave (
        input  in_valid, in_word, abort, out_ready,
        output in_ready, out_valid, out_idx, out_last, done, pop_count
    );

    modport master (
        output in_valid, in_word, abort, out_ready,
        input  in_ready, out_valid, out_idx, out_last, done, pop_count
    );

endinterface

// File: rtl/bit_scan_sequencer_binary_to_bcd.sv
// One-hot to index decoder.
//   diff     : one-hot input vector
//   diff_out : bit position + 1 (0 when diff is zero)
//   eq       : diff is all zeros
//   one_hot  : diff has exactly one bit set
module binary_to_bcd
    import bit_scan_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] diff,
    output logic [CNT_W-1:0]  diff_out,
    output logic              eq,
    output logic              one_hot
);

    always_comb begin
        diff_out = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            if (diff[i]) begin
                diff_out = diff_out | CNT_W'(i + 1);
            end
        end
        eq      = (diff == '0);
        one_hot = !eq && ((diff & (diff - WORD_W'(1))) == '0);
    end

endmodule

// File: rtl/bit_scan_sequencer.sv
// Sequential set-bit enumerator. Accepts a 32-bit word, then emits the index
// of one set bit per output beat (lowest-first when LSB_FIRST=1, otherwise
// highest-first), and pulses done with the population count at the end.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : handshake bundle (bit_scan_sequencer_if.slave)
module bit_scan_sequencer
    import bit_scan_sequencer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bit_scan_sequencer_if.slave         bus
);

    state_t            state;
    logic [WORD_W-1:0] rem;
    logic [CNT_W-1:0]  count;
    logic              done_q;
    logic [CNT_W-1:0]  pop_q;

    logic [WORD_W-1:0] iso_fwd;
    logic [WORD_W-1:0] rem_rev;
    logic [WORD_W-1:0] iso_rev;
    logic [WORD_W-1:0] iso_back;
    logic [WORD_W-1:0] onehot;
    logic [WORD_W-1:0] rest;
    logic [CNT_W-1:0]  dec_out;
    logic              dec_eq;
    logic              dec_one_hot;
    logic              bad;
    logic              last;

    // Lowest set bit of rem; highest is found by isolating in reversed order.
    assign iso_fwd = rem & (~rem + WORD_W'(1));
    assign iso_rev = rem_rev & (~rem_rev + WORD_W'(1));

    for (genvar g = 0; g < WORD_W; g++) begin : g_rev
        assign rem_rev[g]  = rem[WORD_W-1-g];
        assign iso_back[g] = iso_rev[WORD_W-1-g];
    end

    assign onehot = LSB_FIRST ? iso_fwd : iso_back;
    assign rest   = rem & ~onehot;

    binary_to_bcd u_dec (
        .diff     (onehot),
        .diff_out (dec_out),
        .eq       (dec_eq),
        .one_hot  (dec_one_hot)
    );

    // A non-one-hot decode cannot happen in SCAN; treat it as the final beat.
    assign bad  = dec_eq | ~dec_one_hot;
    assign last = (rest == '0) | bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            count  <= '0;
            done_q <= 1'b0;
            pop_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
                rem   <= '0;
                count <= '0;
            end else begin
                // done and pop_count are loaded on entry to FIN so both are
                // valid during the FIN cycle itself.
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            rem   <= bus.in_word;
                            count <= '0;
                            if (bus.in_word == '0) begin
                                state  <= FIN;
                                done_q <= 1'b1;
                                pop_q  <= '0;
                            end else begin
                                state <= SCAN;
                            end
                        end
                    end
                    SCAN: begin
                        if (bad) begin
                            state  <= FIN;
                            rem    <= '0;
                            done_q <= 1'b1;
                            pop_q  <= count;
                        end else if (bus.out_ready) begin
                            rem   <= rest;
                            count <= count + CNT_W'(1);
                            if (last) begin
                                state  <= FIN;
                                done_q <= 1'b1;
                                pop_q  <= count + CNT_W'(1);
                            end
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == SCAN);
    assign bus.out_idx   = (state == SCAN) ? IDX_W'(dec_out - CNT_W'(1)) : '0;
    assign bus.out_last  = (state == SCAN) & last;
    assign bus.done      = done_q;
    assign bus.pop_count = pop_q;

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Directed testbench for bit_scan_sequencer: one LSB-first and one MSB-first
// instance sharing clock and reset.
module tb_bit_scan_sequencer;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bit_scan_sequencer_if if_l ();
    bit_scan_sequencer_if if_m ();

    bit_scan_sequencer #(.LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l)
    );

    bit_scan_sequencer #(.LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word to the LSB-first instance for one cycle.
    task automatic accept_l(input logic [31:0] w);
        if_l.in_valid = 1'b1;
        if_l.in_word  = w;
        step();
        if_l.in_valid = 1'b0;
        if_l.in_word  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if ({if_l.in_ready, if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.done, if_l.pop_count} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0}) begin
            fails++;
            $display("FAIL reset_lsb: rdy=%b vld=%b idx=%0d last=%b done=%b pop=%0d, required rdy=1 vld=0 idx=0 last=0 done=0 pop=0",
                     if_l.in_ready, if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.done, if_l.pop_count);
        end
        tests++;
        if ({if_m.in_ready, if_m.out_valid, if_m.done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_msb: rdy=%b vld=%b done=%b, required 1 0 0", if_m.in_ready, if_m.out_valid, if_m.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lsb_two_bits();
        if_l.out_ready = 1'b1;
        accept_l(32'h8000_0001);
        tests++;
        if ({if_l.out_valid, if_l.out_idx, if_l.out_last} !== {1'b1, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL two_beat0: vld=%b idx=%0d last=%b, required 1 0 0", if_l.out_valid, if_l.out_idx, if_l.out_last);
        end
        step();
        tests++;
        if ({if_l.out_valid, if_l.out_idx, if_l.out_last} !== {1'b1, 5'd31, 1'b1}) begin
            fails++;
            $display("FAIL two_beat1: vld=%b idx=%0d last=%b, required 1 31 1", if_l.out_valid, if_l.out_idx, if_l.out_last);
        end
        step();
        tests++;
        if ({if_l.out_valid, if_l.done, if_l.pop_count, if_l.in_ready} !== {1'b0, 1'b1, 6'd2, 1'b0}) begin
            fails++;
            $display("FAIL two_done: vld=%b done=%b pop=%0d rdy=%b, required 0 1 2 0", if_l.out_valid, if_l.done, if_l.pop_count, if_l.in_ready);
        end
        step();
        tests++;
        if ({if_l.done, if_l.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL two_idle: done=%b rdy=%b, required 0 1", if_l.done, if_l.in_ready);
        end
    endtask

    task automatic test_zero_word();
        accept_l(32'h0000_0000);
        tests++;
        if ({if_l.out_valid, if_l.done, if_l.pop_count, if_l.in_ready} !== {1'b0, 1'b1, 6'd0, 1'b0}) begin
            fails++;
            $display("FAIL zero_done: vld=%b done=%b pop=%0d rdy=%b, required 0 1 0 0", if_l.out_valid, if_l.done, if_l.pop_count, if_l.in_ready);
        end
        step();
        tests++;
        if ({if_l.out_valid, if_l.done, if_l.in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL zero_idle: vld=%b done=%b rdy=%b, required 0 0 1", if_l.out_valid, if_l.done, if_l.in_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [4:0] exp_idx [3];
        exp_idx[0] = 5'd8;
        exp_idx[1] = 5'd4;
        exp_idx[2] = 5'd1;
        if_m.out_ready = 1'b1;
        if_m.in_valid  = 1'b1;
        if_m.in_word   = 32'h0000_0112;
        step();
        if_m.in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({if_m.out_valid, if_m.out_idx, if_m.out_last} !== {1'b1, exp_idx[i], (i == 2)}) begin
                fails++;
                $display("FAIL msb_beat%0d: vld=%b idx=%0d last=%b, required 1 %0d %b",
                         i, if_m.out_valid, if_m.out_idx, if_m.out_last, exp_idx[i], (i == 2));
            end
            step();
        end
        tests++;
        if ({if_m.out_valid, if_m.done, if_m.pop_count} !== {1'b0, 1'b1, 6'd3}) begin
            fails++;
            $display("FAIL msb_done: vld=%b done=%b pop=%0d, required 0 1 3", if_m.out_valid, if_m.done, if_m.pop_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        if_l.out_ready = 1'b0;
        accept_l(32'h0000_00A0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({if_l.out_valid, if_l.out_idx, if_l.out_last} !== {1'b1, 5'd5, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%b idx=%0d last=%b, required 1 5 0", i, if_l.out_valid, if_l.out_idx, if_l.out_last);
            end
            if (i < 2) step();
        end
        if_l.out_ready = 1'b1;
        step();
        tests++;
        if ({if_l.out_valid, if_l.out_idx, if_l.out_last} !== {1'b1, 5'd7, 1'b1}) begin
            fails++;
            $display("FAIL bp_beat1: vld=%b idx=%0d last=%b, required 1 7 1", if_l.out_valid, if_l.out_idx, if_l.out_last);
        end
        step();
        tests++;
        if ({if_l.out_valid, if_l.done, if_l.pop_count} !== {1'b0, 1'b1, 6'd2}) begin
            fails++;
            $display("FAIL bp_done: vld=%b done=%b pop=%0d, required 0 1 2", if_l.out_valid, if_l.done, if_l.pop_count);
        end
        step();
    endtask

    task automatic test_full_word();
        int busy;
        if_l.out_ready = 1'b1;
        accept_l(32'hFFFF_FFFF);
        busy = 1;
        for (int i = 0; i < 32; i++) begin
            tests++;
            if ({if_l.out_valid, if_l.out_idx, if_l.out_last} !== {1'b1, 5'(i), (i == 31)}) begin
                fails++;
                $display("FAIL full_beat%0d: vld=%b idx=%0d last=%b, required 1 %0d %b",
                         i, if_l.out_valid, if_l.out_idx, if_l.out_last, i, (i == 31));
            end
            step();
            busy++;
        end
        tests++;
        if ({if_l.done, if_l.pop_count} !== {1'b1, 6'd32}) begin
            fails++;
            $display("FAIL full_done: done=%b pop=%0d, required 1 32", if_l.done, if_l.pop_count);
        end
        // Count cycles from acceptance until in_ready returns, bounded.
        while (!if_l.in_ready && busy < 100) begin
            step();
            busy++;
        end
        tests++;
        if (busy !== 34) begin
            fails++;
            $display("FAIL full_latency: cycles=%0d, required 34", busy);
        end
    endtask

    task automatic test_abort();
        if_l.out_ready = 1'b1;
        accept_l(32'h0000_F000);
        tests++;
        if (if_l.out_idx !== 5'd12) begin
            fails++;
            $display("FAIL abort_beat0: idx=%0d, required 12", if_l.out_idx);
        end
        step();
        step();
        tests++;
        if ({if_l.out_valid, if_l.out_idx} !== {1'b1, 5'd14}) begin
            fails++;
            $display("FAIL abort_beat2: vld=%b idx=%0d, required 1 14", if_l.out_valid, if_l.out_idx);
        end
        if_l.abort = 1'b1;
        step();
        if_l.abort = 1'b0;
        tests++;
        if ({if_l.in_ready, if_l.out_valid, if_l.done, if_l.pop_count} !== {1'b1, 1'b0, 1'b0, 6'd32}) begin
            fails++;
            $display("FAIL abort_idle: rdy=%b vld=%b done=%b pop=%0d, required 1 0 0 32",
                     if_l.in_ready, if_l.out_valid, if_l.done, if_l.pop_count);
        end
        step();
        tests++;
        if ({if_l.done, if_l.pop_count} !== {1'b0, 6'd32}) begin
            fails++;
            $display("FAIL abort_nodone: done=%b pop=%0d, required 0 32", if_l.done, if_l.pop_count);
        end
        // Abort in IDLE drops the offered word.
        if_l.abort = 1'b1;
        accept_l(32'h0000_0001);
        if_l.abort = 1'b0;
        tests++;
        if ({if_l.in_ready, if_l.out_valid, if_l.done} !== 3'b100) begin
            fails++;
            $display("FAIL abort_drop: rdy=%b vld=%b done=%b, required 1 0 0", if_l.in_ready, if_l.out_valid, if_l.done);
        end
        // Count must restart cleanly after an abort.
        accept_l(32'h0000_0003);
        step();
        step();
        tests++;
        if ({if_l.done, if_l.pop_count} !== {1'b1, 6'd2}) begin
            fails++;
            $display("FAIL abort_after: done=%b pop=%0d, required 1 2", if_l.done, if_l.pop_count);
        end
        step();
    endtask

    task automatic test_reset_mid_scan();
        if_l.out_ready = 1'b1;
        accept_l(32'h0000_00FF);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({if_l.in_ready, if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.done, if_l.pop_count} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0}) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b vld=%b idx=%0d last=%b done=%b pop=%0d, required 1 0 0 0 0 0",
                     if_l.in_ready, if_l.out_valid, if_l.out_idx, if_l.out_last, if_l.done, if_l.pop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if ({if_l.in_ready, if_l.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_after: rdy=%b vld=%b, required 1 0", if_l.in_ready, if_l.out_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        if_l.in_valid  = 1'b0;
        if_l.in_word   = '0;
        if_l.abort     = 1'b0;
        if_l.out_ready = 1'b0;
        if_m.in_valid  = 1'b0;
        if_m.in_word   = '0;
        if_m.abort     = 1'b0;
        if_m.out_ready = 1'b0;

        test_reset();
        test_lsb_two_bits();
        test_zero_word();
        test_msb_first();
        test_backpressure();
        test_full_word();
        test_abort();
        test_reset_mid_scan();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
